// File: rtl/router_out_port_arbiter_pkg.sv
// Shared types and constants for the router output-port arbiter.
package router_out_port_arbiter_pkg;

    localparam int unsigned FLIT_W = 32;

    typedef struct packed {
        logic              head;
        logic              tail;
        logic [FLIT_W-1:0] payload;
    } flit_t;

    typedef enum logic [0:0] {
        StIdle,
        StLocked
    } arb_state_e;

    localparam int unsigned PORT_N     = 0;
    localparam int unsigned PORT_S     = 1;
    localparam int unsigned PORT_E     = 2;
    localparam int unsigned PORT_W     = 3;
    localparam int unsigned PORT_LOCAL = 4;

endpackage

// File: rtl/router_out_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after ptr_i, wrapping mod N_IN.
module router_out_port_arbiter_rr_pick #(
    parameter int unsigned N_IN  = 5,
    parameter int unsigned IDX_W = 3
) (
    input  logic [N_IN-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_IN-1:0]  gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;
    logic             found;

    always_comb begin
        gnt_o    = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 1; k <= N_IN; k++) begin
            cand     = (32'(ptr_i) + k) % N_IN;
            cand_idx = IDX_W'(cand);
            if (!found && req_i[cand_idx]) begin
                gnt_o[cand_idx] = 1'b1;
                idx_o           = cand_idx;
                found           = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/router_out_port_arbiter.sv
// Wormhole output-port arbiter: round-robin on heads, lock until tail, credit-gated,
// with a stall watchdog.
module router_out_port_arbiter
    import router_out_port_arbiter_pkg::*;
#(
    parameter int unsigned N_IN        = 5,
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned CREDITS     = 4,
    parameter int unsigned STALL_LIMIT = 64,
    localparam int unsigned IDX_W      = (N_IN > 1) ? $clog2(N_IN) : 1,
    localparam int unsigned CNT_W      = $clog2(CREDITS + 1),
    localparam int unsigned WD_W       = $clog2(STALL_LIMIT + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_IN-1:0]       req_valid_i,
    input  logic [N_IN-1:0]       req_head_i,
    input  logic [N_IN-1:0]       req_tail_i,
    input  logic [N_IN*WIDTH-1:0] req_flit_i,
    output logic [N_IN-1:0]       req_ready_o,
    output logic                  out_valid_o,
    output logic [WIDTH-1:0]      out_flit_o,
    output logic                  out_head_o,
    output logic                  out_tail_o,
    input  logic                  credit_in_i,
    output logic [CNT_W-1:0]      credit_cnt_o,
    output logic                  lock_active_o,
    output logic [IDX_W-1:0]      owner_idx_o,
    output logic                  stall_alarm_o,
    output logic                  credit_err_o
);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] credit_q, credit_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             credit_err_q, credit_err_d;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_flit_q;
    logic             out_head_q, out_tail_q;

    logic [N_IN-1:0]  pick_gnt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             xfer;
    logic             sel_head, sel_tail;
    logic [WIDTH-1:0] sel_flit;

    router_out_port_arbiter_rr_pick #(
        .N_IN  (N_IN),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i (req_valid_i & req_head_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_comb begin
        req_ready_o = '0;
        if (credit_q != '0) begin
            if (state_q == StIdle) begin
                req_ready_o = pick_any ? pick_gnt : '0;
            end else begin
                for (int unsigned i = 0; i < N_IN; i++) begin
                    req_ready_o[i] = (IDX_W'(i) == owner_q) && req_valid_i[i];
                end
            end
        end
        xfer = |req_ready_o;

        sel_flit = '0;
        sel_head = 1'b0;
        sel_tail = 1'b0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (req_ready_o[i]) begin
                sel_flit = req_flit_i[i*WIDTH +: WIDTH];
                sel_head = req_head_i[i];
                sel_tail = req_tail_i[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        credit_d     = credit_q;
        credit_err_d = credit_err_q;
        wd_d         = wd_q;

        if (xfer) begin
            if (state_q == StIdle) begin
                owner_d = pick_idx;
                if (sel_tail) begin
                    rr_ptr_d = pick_idx;
                end else begin
                    state_d = StLocked;
                end
            end else if (sel_tail) begin
                state_d  = StIdle;
                rr_ptr_d = owner_q;
            end
        end

        unique case ({xfer, credit_in_i})
            2'b10: credit_d = credit_q - 1'b1;
            2'b01: begin
                if (credit_q == CNT_W'(CREDITS)) begin
                    credit_err_d = 1'b1;
                end else begin
                    credit_d = credit_q + 1'b1;
                end
            end
            default: credit_d = credit_q;
        endcase

        if (xfer) begin
            wd_d = '0;
        end else if ((|req_valid_i) && (wd_q != WD_W'(STALL_LIMIT))) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            owner_q      <= '0;
            rr_ptr_q     <= IDX_W'(N_IN - 1);
            credit_q     <= CNT_W'(CREDITS);
            credit_err_q <= 1'b0;
            wd_q         <= '0;
            out_valid_q  <= 1'b0;
            out_flit_q   <= '0;
            out_head_q   <= 1'b0;
            out_tail_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            credit_q     <= credit_d;
            credit_err_q <= credit_err_d;
            wd_q         <= wd_d;
            out_valid_q  <= xfer;
            // Payload only follows a transfer so idle cycles keep the last flit.
            if (xfer) begin
                out_flit_q <= sel_flit;
                out_head_q <= sel_head;
                out_tail_q <= sel_tail;
            end
        end
    end

    assign out_valid_o   = out_valid_q;
    assign out_flit_o    = out_flit_q;
    assign out_head_o    = out_head_q;
    assign out_tail_o    = out_tail_q;
    assign credit_cnt_o  = credit_q;
    assign lock_active_o = (state_q == StLocked);
    assign owner_idx_o   = owner_q;
    assign stall_alarm_o = (wd_q == WD_W'(STALL_LIMIT));
    assign credit_err_o  = credit_err_q;

endmodule

// File: tb/tb_router_out_port_arbiter.sv
// Directed bench for router_out_port_arbiter: vector table plus multi-cycle sequences.
module tb_router_out_port_arbiter;

    localparam int unsigned N_IN  = 5;
    localparam int unsigned WIDTH = 32;

    logic                  clk;
    logic                  rst_n;
    logic [N_IN-1:0]       req_valid, req_head, req_tail, req_ready;
    logic [N_IN*WIDTH-1:0] req_flit;
    logic                  out_valid, out_head, out_tail;
    logic [WIDTH-1:0]      out_flit;
    logic                  credit_in;
    logic [2:0]            credit_cnt;
    logic                  lock_active;
    logic [2:0]            owner_idx;
    logic                  stall_alarm, credit_err;

    int checks = 0;
    int errors = 0;

    router_out_port_arbiter #(
        .N_IN        (N_IN),
        .WIDTH       (WIDTH),
        .CREDITS     (4),
        .STALL_LIMIT (64)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_i   (req_valid),
        .req_head_i    (req_head),
        .req_tail_i    (req_tail),
        .req_flit_i    (req_flit),
        .req_ready_o   (req_ready),
        .out_valid_o   (out_valid),
        .out_flit_o    (out_flit),
        .out_head_o    (out_head),
        .out_tail_o    (out_tail),
        .credit_in_i   (credit_in),
        .credit_cnt_o  (credit_cnt),
        .lock_active_o (lock_active),
        .owner_idx_o   (owner_idx),
        .stall_alarm_o (stall_alarm),
        .credit_err_o  (credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] valid;
        logic [4:0] head;
        logic [4:0] tail;
        logic       cin;
        logic [4:0] ready;
        logic [2:0] cc;
        logic       lock;
        logic [2:0] owner;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flits(input int tag);
        for (int i = 0; i < N_IN; i++) begin
            req_flit[i*WIDTH +: WIDTH] = {8'hC0, 8'(tag), 8'h00, 8'(i)};
        end
    endtask

    task automatic drive(input logic [4:0] v, input logic [4:0] h, input logic [4:0] t,
                         input logic c);
        req_valid = v;
        req_head  = h;
        req_tail  = t;
        credit_in = c;
    endtask

    initial begin
        logic [WIDTH-1:0] exp_flit;
        logic             exp_h, exp_t;

        //             valid     head      tail      cin   ready     cc    lk    own
        vecs[0]  = '{5'b00100, 5'b00100, 5'b00100, 1'b0, 5'b00100, 3'd3, 1'b0, 3'd2};
        vecs[1]  = '{5'b01011, 5'b01011, 5'b01011, 1'b1, 5'b01000, 3'd3, 1'b0, 3'd3};
        vecs[2]  = '{5'b01011, 5'b01011, 5'b01011, 1'b1, 5'b00001, 3'd3, 1'b0, 3'd0};
        vecs[3]  = '{5'b01011, 5'b01011, 5'b01011, 1'b1, 5'b00010, 3'd3, 1'b0, 3'd1};
        vecs[4]  = '{5'b01011, 5'b01011, 5'b01011, 1'b1, 5'b01000, 3'd3, 1'b0, 3'd3};
        vecs[5]  = '{5'b01011, 5'b01011, 5'b01011, 1'b1, 5'b00001, 3'd3, 1'b0, 3'd0};
        vecs[6]  = '{5'b00011, 5'b00011, 5'b00001, 1'b0, 5'b00010, 3'd2, 1'b1, 3'd1};
        vecs[7]  = '{5'b00011, 5'b00001, 5'b00001, 1'b1, 5'b00010, 3'd2, 1'b1, 3'd1};
        vecs[8]  = '{5'b00011, 5'b00001, 5'b00001, 1'b1, 5'b00010, 3'd2, 1'b1, 3'd1};
        vecs[9]  = '{5'b00011, 5'b00001, 5'b00011, 1'b1, 5'b00010, 3'd2, 1'b0, 3'd1};
        vecs[10] = '{5'b00001, 5'b00001, 5'b00001, 1'b1, 5'b00001, 3'd2, 1'b0, 3'd0};
        vecs[11] = '{5'b00100, 5'b00000, 5'b00100, 1'b0, 5'b00000, 3'd2, 1'b0, 3'd0};

        rst_n = 1'b0;
        drive(5'b0, 5'b0, 5'b0, 1'b0);
        set_flits(0);
        step();
        chk("rst_credit_cnt", 32'(credit_cnt), 32'd4);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_lock", 32'(lock_active), 32'd0);
        chk("rst_owner", 32'(owner_idx), 32'd0);
        chk("rst_alarm_err", {30'd0, stall_alarm, credit_err}, 32'd0);
        rst_n = 1'b1;
        step();

        // Single-flit, round-robin order 3,0,1,3,0 and wormhole lock against input 0.
        for (int v = 0; v < 12; v++) begin
            drive(vecs[v].valid, vecs[v].head, vecs[v].tail, vecs[v].cin);
            set_flits(v + 1);
            exp_flit = '0;
            exp_h    = 1'b0;
            exp_t    = 1'b0;
            for (int i = 0; i < N_IN; i++) begin
                if (vecs[v].ready[i]) begin
                    exp_flit = req_flit[i*WIDTH +: WIDTH];
                    exp_h    = vecs[v].head[i];
                    exp_t    = vecs[v].tail[i];
                end
            end
            #1;
            chk($sformatf("v%0d_ready", v), 32'(req_ready), 32'(vecs[v].ready));
            step();
            chk($sformatf("v%0d_out_valid", v), 32'(out_valid), 32'(|vecs[v].ready));
            if (|vecs[v].ready) begin
                chk($sformatf("v%0d_out_flit", v), out_flit, exp_flit);
                chk($sformatf("v%0d_out_ht", v), {30'd0, out_head, out_tail},
                    {30'd0, exp_h, exp_t});
            end
            chk($sformatf("v%0d_credit", v), 32'(credit_cnt), 32'(vecs[v].cc));
            chk($sformatf("v%0d_lock", v), 32'(lock_active), 32'(vecs[v].lock));
            chk($sformatf("v%0d_owner", v), 32'(owner_idx), 32'(vecs[v].owner));
        end

        // Credit exhaustion: 4 of 5 accepted, then one credit lets one more through.
        drive(5'b0, 5'b0, 5'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        step();
        drive(5'b00100, 5'b00100, 5'b00100, 1'b0);
        for (int n = 0; n < 4; n++) begin
            #1;
            chk($sformatf("cr_ready%0d", n), 32'(req_ready), 32'b00100);
            step();
            chk($sformatf("cr_cnt%0d", n), 32'(credit_cnt), 32'(3 - n));
        end
        #1;
        chk("cr_empty_ready", 32'(req_ready), 32'd0);
        step();
        chk("cr_empty_out_valid", 32'(out_valid), 32'd0);
        credit_in = 1'b1;
        #1;
        chk("cr_pulse_ready", 32'(req_ready), 32'd0);
        step();
        credit_in = 1'b0;
        chk("cr_pulse_cnt", 32'(credit_cnt), 32'd1);
        #1;
        chk("cr_one_ready", 32'(req_ready), 32'b00100);
        step();
        chk("cr_one_cnt", 32'(credit_cnt), 32'd0);
        #1;
        chk("cr_after_ready", 32'(req_ready), 32'd0);
        drive(5'b0, 5'b0, 5'b0, 1'b1);
        step();
        drive(5'b00100, 5'b00100, 5'b00100, 1'b1);
        #1;
        chk("cr_both_ready", 32'(req_ready), 32'b00100);
        step();
        chk("cr_both_cnt", 32'(credit_cnt), 32'd1);

        // Watchdog: drain the last credit, then starve input 4 for 64 cycles.
        drive(5'b10000, 5'b10000, 5'b10000, 1'b0);
        #1;
        chk("wd_drain_ready", 32'(req_ready), 32'b10000);
        step();
        for (int n = 0; n < 63; n++) step();
        chk("wd_alarm_63", 32'(stall_alarm), 32'd0);
        step();
        chk("wd_alarm_64", 32'(stall_alarm), 32'd1);
        for (int n = 0; n < 3; n++) step();
        chk("wd_alarm_hold", 32'(stall_alarm), 32'd1);
        credit_in = 1'b1;
        step();
        credit_in = 1'b0;
        #1;
        chk("wd_xfer_ready", 32'(req_ready), 32'b10000);
        chk("wd_alarm_xfer_cycle", 32'(stall_alarm), 32'd1);
        step();
        chk("wd_alarm_cleared", 32'(stall_alarm), 32'd0);
        chk("wd_out_valid", 32'(out_valid), 32'd1);

        // Reset while LOCKED, then a credit at full count flags credit_err.
        drive(5'b0, 5'b0, 5'b0, 1'b1);
        step();
        drive(5'b00010, 5'b00010, 5'b00000, 1'b0);
        #1;
        chk("rl_head_ready", 32'(req_ready), 32'b00010);
        step();
        chk("rl_locked", 32'(lock_active), 32'd1);
        chk("rl_owner", 32'(owner_idx), 32'd1);
        drive(5'b00010, 5'b00000, 5'b00000, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rl_rst_cnt", 32'(credit_cnt), 32'd4);
        chk("rl_rst_lock", 32'(lock_active), 32'd0);
        chk("rl_rst_out_valid", 32'(out_valid), 32'd0);
        chk("rl_rst_err", 32'(credit_err), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(5'b0, 5'b0, 5'b0, 1'b1);
        step();
        credit_in = 1'b0;
        chk("rl_err_set", 32'(credit_err), 32'd1);
        chk("rl_err_cnt", 32'(credit_cnt), 32'd4);
        step();
        chk("rl_err_sticky", 32'(credit_err), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
